// File: rtl/cordic_tdm_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC across NCH NCO channels.
// Per-channel phase state lives in cordic_tdm_sched_ch; a tag pipe steers results back.

module cordic_tdm_sched_ch #(
  parameter int PW = 20
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_adv,
  input  logic          i_we,
  input  logic          i_clr,
  input  logic [PW-1:0] i_fcw,
  output logic [PW-1:0] o_acc
);
  logic [PW-1:0] acc_q, acc_d, fcw_q, fcw_d;

  // Clear beats a same-cycle accumulate; the accumulate itself uses the old fcw.
  always_comb begin
    acc_d = acc_q;
    fcw_d = fcw_q;
    if (i_adv) acc_d = acc_q + fcw_q;
    if (i_we) begin
      fcw_d = i_fcw;
      if (i_clr) acc_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q <= '0;
      fcw_q <= '0;
    end else begin
      acc_q <= acc_d;
      fcw_q <= fcw_d;
    end
  end

  assign o_acc = acc_q;
endmodule

module cordic_tdm_sched #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int IW  = 13,
  parameter int OW  = 13,
  parameter int PW  = 20,
  parameter int LAT = 18
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_cfg_we,
  input  logic [CHW-1:0]       i_cfg_ch,
  input  logic [PW-1:0]        i_cfg_fcw,
  input  logic                 i_cfg_clr,
  input  logic [NCH-1:0]       i_ch_en,
  input  logic [IW-1:0]        i_amp,
  output logic                 o_cor_ce,
  output logic [IW-1:0]        o_cor_x,
  output logic [IW-1:0]        o_cor_y,
  output logic [PW-1:0]        o_cor_phase,
  output logic                 o_cor_aux,
  input  logic [OW-1:0]        i_cor_x,
  input  logic [OW-1:0]        i_cor_y,
  input  logic                 i_cor_aux,
  output logic                 o_valid,
  output logic [CHW-1:0]       o_ch,
  output logic [OW-1:0]        o_xval,
  output logic [OW-1:0]        o_yval,
  output logic                 o_err
);
  logic [CHW-1:0]           slot_q, slot_d;
  logic [NCH-1:0][PW-1:0]   acc;
  logic [PW-1:0]            phase_q, phase_d;
  logic [IW-1:0]            x_q, x_d;
  logic                     aux_q, aux_d;
  logic [LAT:0]             vld_pipe_q, vld_pipe_d;
  logic [LAT:0][CHW-1:0]    ch_pipe_q, ch_pipe_d;
  logic                     valid_q, valid_d, err_q, err_d;
  logic [CHW-1:0]           ch_q, ch_d;
  logic [OW-1:0]            xval_q, xval_d, yval_q, yval_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    cordic_tdm_sched_ch #(.PW(PW)) u_ch (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_adv   (i_ce && i_ch_en[g] && (slot_q == CHW'(g))),
      .i_we    (i_cfg_we && (i_cfg_ch == CHW'(g))),
      .i_clr   (i_cfg_clr),
      .i_fcw   (i_cfg_fcw),
      .o_acc   (acc[g])
    );
  end

  always_comb begin
    slot_d     = slot_q;
    phase_d    = phase_q;
    x_d        = x_q;
    aux_d      = aux_q;
    vld_pipe_d = vld_pipe_q;
    ch_pipe_d  = ch_pipe_q;
    valid_d    = 1'b0;
    ch_d       = ch_q;
    xval_d     = xval_q;
    yval_d     = yval_q;
    err_d      = err_q;
    if (i_ce) begin
      slot_d     = slot_q + CHW'(1);
      phase_d    = acc[slot_q];
      x_d        = i_amp;
      aux_d      = i_ch_en[slot_q];
      vld_pipe_d = {vld_pipe_q[LAT-1:0], i_ch_en[slot_q]};
      ch_pipe_d  = {ch_pipe_q[LAT-1:0], slot_q};
      // Tail of the tag pipe lines up with the CORDIC output this cycle.
      if (vld_pipe_q[LAT]) begin
        valid_d = 1'b1;
        ch_d    = ch_pipe_q[LAT];
        xval_d  = i_cor_x;
        yval_d  = i_cor_y;
      end
      if (vld_pipe_q[LAT] != i_cor_aux) err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_q     <= '0;
      phase_q    <= '0;
      x_q        <= '0;
      aux_q      <= 1'b0;
      vld_pipe_q <= '0;
      ch_pipe_q  <= '0;
      valid_q    <= 1'b0;
      ch_q       <= '0;
      xval_q     <= '0;
      yval_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      phase_q    <= phase_d;
      x_q        <= x_d;
      aux_q      <= aux_d;
      vld_pipe_q <= vld_pipe_d;
      ch_pipe_q  <= ch_pipe_d;
      valid_q    <= valid_d;
      ch_q       <= ch_d;
      xval_q     <= xval_d;
      yval_q     <= yval_d;
      err_q      <= err_d;
    end
  end

  assign o_cor_ce    = i_ce;
  assign o_cor_x     = x_q;
  assign o_cor_y     = '0;
  assign o_cor_phase = phase_q;
  assign o_cor_aux   = aux_q;
  assign o_valid     = valid_q;
  assign o_ch        = ch_q;
  assign o_xval      = xval_q;
  assign o_yval      = yval_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_cordic_tdm_sched.sv
// Bench for cordic_tdm_sched: CORDIC stub as a LAT-deep delay line, queue-based reference model.
module tb_cordic_tdm_sched;
  localparam int NCH = 4, CHW = 2, IW = 13, OW = 13, PW = 20, LAT = 18;

  logic           clk = 1'b0, rst;
  logic           ce, we, clr;
  logic [CHW-1:0] cfg_ch;
  logic [PW-1:0]  cfg_fcw;
  logic [NCH-1:0] ch_en;
  logic [IW-1:0]  amp;
  logic           cor_ce, cor_aux, c_aux, valid, err;
  logic [IW-1:0]  cor_x, cor_y;
  logic [PW-1:0]  cor_phase;
  logic [OW-1:0]  c_x, c_y, xval, yval;
  logic [CHW-1:0] och;
  bit             force0 = 1'b0;

  always #5 clk = ~clk;

  cordic_tdm_sched #(.NCH(NCH), .CHW(CHW), .IW(IW), .OW(OW), .PW(PW), .LAT(LAT)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_cfg_we(we), .i_cfg_ch(cfg_ch),
    .i_cfg_fcw(cfg_fcw), .i_cfg_clr(clr), .i_ch_en(ch_en), .i_amp(amp),
    .o_cor_ce(cor_ce), .o_cor_x(cor_x), .o_cor_y(cor_y), .o_cor_phase(cor_phase),
    .o_cor_aux(cor_aux), .i_cor_x(c_x), .i_cor_y(c_y), .i_cor_aux(c_aux),
    .o_valid(valid), .o_ch(och), .o_xval(xval), .o_yval(yval), .o_err(err)
  );

  // CORDIC stand-in: results encode the issued phase and amplitude so routing is visible.
  logic [LAT-1:0][OW-1:0] dx, dy;
  logic [LAT-1:0]         da;
  logic [OW-1:0]          fx, fy;
  assign fx    = cor_phase[PW-1 -: OW] + cor_x;
  assign fy    = cor_x - cor_phase[OW-1:0] + cor_y;
  assign c_x   = dx[LAT-1];
  assign c_y   = dy[LAT-1];
  assign c_aux = da[LAT-1] & ~force0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dx <= '0; dy <= '0; da <= '0;
    end else if (cor_ce) begin
      dx <= {dx[LAT-2:0], fx};
      dy <= {dy[LAT-2:0], fy};
      da <= {da[LAT-2:0], cor_aux};
    end
  end

  // Reference model
  typedef struct { bit en; int ch; logic [PW-1:0] ph; logic [IW-1:0] amp; } rec_t;
  rec_t           q[$];
  int             s;
  logic [PW-1:0]  macc [NCH];
  logic [PW-1:0]  mfcw [NCH];
  logic           e_valid, e_err, e_aux;
  logic [CHW-1:0] e_ch;
  logic [OW-1:0]  e_x, e_y;
  logic [PW-1:0]  e_ph;
  logic [IW-1:0]  e_cx;
  int nvec = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rec_t b;
    b.en = 0; b.ch = 0; b.ph = '0; b.amp = '0;
    q.delete();
    for (int i = 0; i <= LAT; i++) q.push_back(b);
    s = 0;
    for (int i = 0; i < NCH; i++) begin macc[i] = '0; mfcw[i] = '0; end
    e_valid = 0; e_err = 0; e_aux = 0; e_ch = '0; e_x = '0; e_y = '0; e_ph = '0; e_cx = '0;
  endtask

  task automatic model_edge();
    rec_t r, n;
    if (ce) begin
      r = q.pop_front();
      n.en = ch_en[s]; n.ch = s; n.ph = macc[s]; n.amp = amp;
      q.push_back(n);
      e_ph = n.ph; e_cx = amp; e_aux = n.en;
      if (n.en) macc[s] = macc[s] + mfcw[s];
      e_valid = r.en;
      if (r.en) begin
        e_ch = CHW'(r.ch);
        e_x  = r.ph[PW-1 -: OW] + r.amp;
        e_y  = r.amp - r.ph[OW-1:0];
        if (force0) e_err = 1;
      end
      s = (s + 1) % NCH;
    end else e_valid = 0;
    if (we) begin
      mfcw[cfg_ch] = cfg_fcw;
      if (clr) macc[cfg_ch] = '0;
    end
  endtask

  task automatic check_all();
    chk("o_cor_ce", 32'(cor_ce), 32'(ce));
    chk("o_cor_phase", 32'(cor_phase), 32'(e_ph));
    chk("o_cor_x", 32'(cor_x), 32'(e_cx));
    chk("o_cor_y", 32'(cor_y), 32'h0);
    chk("o_cor_aux", 32'(cor_aux), 32'(e_aux));
    chk("o_valid", 32'(valid), 32'(e_valid));
    chk("o_ch", 32'(och), 32'(e_ch));
    chk("o_xval", 32'(xval), 32'(e_x));
    chk("o_yval", 32'(yval), 32'(e_y));
    chk("o_err", 32'(err), 32'(e_err));
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    check_all();
  endtask

  // Asserted between edges to exercise the asynchronous clear.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [PW-1:0] f, input bit c);
    we = 1'b1; cfg_ch = CHW'(ch); cfg_fcw = f; clr = c;
    step();
    we = 1'b0; clr = 1'b0;
  endtask

  int first;

  initial begin
    rst = 1'b1; ce = 0; we = 0; clr = 0; cfg_ch = '0; cfg_fcw = '0; ch_en = '0; amp = '0;
    model_reset();
    #12 check_all();
    @(posedge clk); #1 rst = 1'b0;

    // Only ch0; fcw written while ce is low so the first issue sees phase 0
    cfg(0, 20'd16131, 1'b0);
    ch_en = 4'b0001; amp = 13'd2000; ce = 1'b1;
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (valid && first < 0) first = i;
    end
    chk("first_valid_cycle", 32'(first), 32'd20);

    // All four channels at multiples of the base step
    for (int k = 1; k < NCH; k++) cfg(k, 20'(16131 * (k + 1)), 1'b0);
    ch_en = 4'b1111;
    for (int i = 0; i < 40; i++) step();

    // Phase walk through the 2^PW wrap
    cfg(0, 20'hFFFFF, 1'b1);
    for (int i = 0; i < 24; i++) step();

    // Write+clear landing on ch1's own issue cycle
    while (s != 1) step();
    cfg(1, 20'd12345, 1'b1);
    for (int i = 0; i < 24; i++) step();

    // Missing aux from the CORDIC raises a sticky error
    ch_en = 4'b0100;
    force0 = 1'b1;
    for (int i = 0; i < 30; i++) step();
    force0 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();

    // Clock-enable at 1-of-3 with random traffic, then a mid-run reset
    for (int k = 0; k < NCH; k++) cfg(k, 20'($urandom), 1'b0);
    for (int i = 0; i < 90; i++) begin
      ce = (i % 3 == 0);
      ch_en = NCH'($urandom);
      amp = IW'($urandom);
      step();
    end
    do_reset();
    ce = 1'b1; ch_en = 4'b1111;
    for (int k = 0; k < NCH; k++) cfg(k, 20'($urandom), 1'b0);
    for (int i = 0; i < 30; i++) step();

    // Fully random traffic including config writes
    for (int i = 0; i < 400; i++) begin
      ce = ($urandom_range(3) != 0);
      ch_en = NCH'($urandom);
      amp = IW'($urandom);
      we = ($urandom_range(4) == 0);
      cfg_ch = CHW'($urandom);
      cfg_fcw = 20'($urandom);
      clr = ($urandom_range(2) == 0);
      step();
    end
    we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/cordic_tdm_sched.md
# cordic_tdm_sched

Time-division scheduler that shares one pipelined `cordic` rotator between `NCH` independent NCO/downconversion channels. It owns one phase accumulator and one frequency control word per channel and issues one rotation per clock-enable cycle in fixed round-robin order. A tag pipeline tracks each issued operation through the CORDIC latency, and the block demultiplexes the rotated results back to per-channel output strobes. It sits between the register/config logic and the `cordic` instance in the dnconv chain.

## Interface
- `NCH`, 4: number of channels; must be a power of two, at least 2.
- `CHW`, 2: channel index width, equal to log2(`NCH`).
- `IW`, 13: CORDIC input sample width.
- `OW`, 13: CORDIC output sample width.
- `PW`, 20: phase and frequency-word width.
- `LAT`, 18: CORDIC latency in `i_ce` cycles, from registered input to `o_xval`/`o_yval`/`o_aux`.
- `i_clk`  in  1  single clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_ce`  in  1  global clock enable; all state advances only when high.
- `i_cfg_we`  in  1  config write strobe.
- `i_cfg_ch`  in  CHW  channel addressed by the write.
- `i_cfg_fcw`  in  PW  frequency control word to store.
- `i_cfg_clr`  in  1  on a write, also zero that channel's phase accumulator.
- `i_ch_en`  in  NCH  per-channel enable mask (level).
- `i_amp`  in  IW  signed amplitude driven as CORDIC x input.
- `o_cor_ce`, `o_cor_x`, `o_cor_y`, `o_cor_phase`, `o_cor_aux`  out  1/IW/IW/PW/1  to the CORDIC `i_ce`, `i_xval`, `i_yval`, `i_phase` and `i_aux` inputs.
- `i_cor_x`, `i_cor_y`, `i_cor_aux`  in  OW/OW/1  from the CORDIC `o_xval`, `o_yval` and `o_aux` outputs.
- `o_valid`  out  1  one-cycle result strobe.
- `o_ch`  out  CHW  channel of the current result.
- `o_xval`, `o_yval`  out  OW  rotated result (cos, sin scaled by `i_amp`).
- `o_err`  out  1  sticky tag/aux mismatch flag.

## Operation
- Reset values:
  - slot counter, all accumulators, all FCWs, `o_cor_*` (except `o_cor_ce`), the tag pipeline, `o_valid`, `o_ch`, `o_xval`, `o_yval` and `o_err` are all 0.
  - `o_cor_ce` equals `i_ce` combinationally.
- Slot counter `s` counts 0..NCH-1 and wraps to 0. It increments by one on every `i_ce` cycle; there is no idle state.
- Issue, on each `i_ce` cycle with slot `s`, registered:
  - `o_cor_phase` = acc[s], `o_cor_x` = `i_amp`, `o_cor_y` = 0, `o_cor_aux` = `i_ch_en[s]`.
  - If `i_ch_en[s]` is high: acc[s] <= acc[s] + fcw[s], modulo 2^PW. Wrap-around is natural; there is no saturation.
  - If `i_ch_en[s]` is low: acc[s] is held, and the slot still issues with aux=0 as a bubble.
- Config write, on `i_cfg_we` with `i_ce` ignored (writes always land):
  - fcw[`i_cfg_ch`] <= `i_cfg_fcw`.
  - If `i_cfg_clr` is high: acc[`i_cfg_ch`] <= 0. The clear wins over a same-cycle accumulate.
  - A write landing on the same cycle as that channel's issue: the issue uses the old acc and old fcw, and the new fcw applies from the next visit.
- Tag pipeline: depth `LAT`+1 entries of {valid, ch}. It shifts only on `i_ce`. Entry 0 is loaded with {`i_ch_en[s]`, s} at issue.
- Result capture, on an `i_ce` cycle where the tail tag is valid:
  - `o_xval` <= `i_cor_x`, `o_yval` <= `i_cor_y`, `o_ch` <= tag ch, `o_valid` <= 1.
  - On all other cycles `o_valid` <= 0 and the data outputs hold.
- Error: on any `i_ce` cycle where tail tag valid != `i_cor_aux`, `o_err` <= 1. It stays set until reset.
- Disabling a channel mid-flight does not cancel its already-issued operations; they still produce `o_valid`.

## Timing
- Throughput: one CORDIC operation per `i_ce` cycle. Each enabled channel gets one result every `NCH` `i_ce` cycles.
- Latency from slot-select cycle to `o_valid`: `LAT`+2 `i_ce` cycles.
  - 1 for the issue register.
  - `LAT` through the CORDIC.
  - 1 for the output register.
- `i_ce` low freezes the slot counter, accumulators, tag pipeline and outputs. `o_valid` is forced to 0 on that cycle.
- `i_reset` asserted mid-operation clears all state immediately (asynchronously). The first issue after release is slot 0 with phase 0.

## Test plan
- Only ch0 enabled, fcw0=16131, `i_amp`=2000, NCH=4, LAT=18 → `o_cor_phase` for ch0 issues is 0, 16131, 32262, …. First `o_valid` with `o_ch`=0 arrives 20 cycles after reset release, repeats every 4 cycles; `o_xval` ≈ 2000·K·cos(phase).
- All 4 enabled, fcw={1,2,3,4}·16131 → `o_ch` cycles 0,1,2,3 with `o_valid` continuously high after fill; each channel's phase step matches its fcw.
- fcw0=0xFFFFF, acc walk → acc0 goes 0, 0xFFFFF, 0xFFFFE (mod 2^20 wrap); `o_err` stays 0.
- Write fcw1 with `i_cfg_clr`=1 on ch1's issue cycle → that issue uses the old phase; the next ch1 issue has phase 0, and the following one equals the new fcw.
- Stub CORDIC with aux forced 0 while ch2 is enabled → `o_err` rises on ch2's first expected result and stays high; reset clears it.
- Toggle `i_ce` 1-of-3 cycles, then assert `i_reset` mid-run → results match the full-rate sequence in `i_ce` cycles with no valids while `i_ce` is low. After reset every output reads 0 and the sequence restarts from slot 0, phase 0.
